// File: rtl/heq_pkg.sv
// Shared types and constants for the histogram-equalizer frame sequencer.
package heq_pkg;

  localparam int unsigned CDF_MIN_W = 20;

  localparam int unsigned WDOG_CYCLES_DEFAULT = 400000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    HIST  = 3'd2,
    MAP   = 3'd3,
    DONE  = 3'd4
  } heq_seq_state_t;

endpackage : heq_pkg

// File: rtl/heq_frame_sequencer.sv
// Frame-level sequencer: flush, histogram/CDF, mapping, done; ping-pongs the input buffer half.
// Optional per-phase watchdog on HIST and MAP is enabled by defining HEQ_SEQ_WATCHDOG_EN.
module heq_frame_sequencer
  import heq_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 4,
  parameter int unsigned CNT_W        = 20
`ifdef HEQ_SEQ_WATCHDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES  = WDOG_CYCLES_DEFAULT
`endif
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  output logic                 hist_start,
  input  logic                 hist_done,
  input  logic                 cdf_valid,
  input  logic [CDF_MIN_W-1:0] cdf_min_in,
  output logic [CDF_MIN_W-1:0] cdf_min,
  output logic                 map_start,
  input  logic                 map_done,
  output logic                 input_base_offset,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
`ifdef HEQ_SEQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST  = CNT_W'(WDOG_CYCLES - 1);
`endif

  heq_seq_state_t       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cdf_seen_q, cdf_seen_d;
  logic [CDF_MIN_W-1:0] cdf_min_q, cdf_min_d;
  logic                 err_q, err_d;
  logic                 ibo_q, ibo_d;
  logic                 map_start_q, map_start_d;

  // NOTE: every state register uses non-blocking assignment and an async
  // reset; blocking here would create ordering races between always_ff blocks.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cdf_seen_q  <= 1'b0;
      cdf_min_q   <= '0;
      err_q       <= 1'b0;
      ibo_q       <= 1'b0;
      map_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cdf_seen_q  <= cdf_seen_d;
      cdf_min_q   <= cdf_min_d;
      err_q       <= err_d;
      ibo_q       <= ibo_d;
      map_start_q <= map_start_d;
    end
  end

  // NOTE: all next-state signals get a default before the case so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cdf_seen_d  = cdf_seen_q;
    cdf_min_d   = cdf_min_q;
    err_d       = err_q;
    ibo_d       = ibo_q;
    map_start_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (frame_valid) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end

      FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = HIST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HIST: begin
        // Only the first cdf_valid of a frame is taken, including one that
        // coincides with hist_done.
        if (cdf_valid && !cdf_seen_q) begin
          cdf_min_d  = cdf_min_in;
          cdf_seen_d = 1'b1;
        end
        if (hist_done) begin
          state_d     = MAP;
          map_start_d = 1'b1;
          cnt_d       = '0;
          if (!cdf_seen_q && !cdf_valid) err_d = 1'b1;
        end
`ifdef HEQ_SEQ_WATCHDOG_EN
        else if (cnt_q == WDOG_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      MAP: begin
        if (map_done) begin
          state_d = DONE;
        end
`ifdef HEQ_SEQ_WATCHDOG_EN
        else if (cnt_q == WDOG_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      DONE: begin
        state_d    = IDLE;
        ibo_d      = ~ibo_q;
        cdf_seen_d = 1'b0;
        err_d      = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign frame_ready       = (state_q == IDLE);
  assign busy              = (state_q != IDLE);
  assign hist_start        = (state_q == HIST);
  assign map_start         = map_start_q;
  assign frame_done        = (state_q == DONE);
  assign frame_err         = (state_q == DONE) && err_q;
  assign cdf_min           = cdf_min_q;
  assign input_base_offset = ibo_q;

endmodule : heq_frame_sequencer

// File: tb/tb_heq_frame_sequencer.sv
// Directed bench for heq_frame_sequencer; watchdog scenario runs when HEQ_SEQ_WATCHDOG_EN is defined.
module tb_heq_frame_sequencer;
  import heq_pkg::*;

  logic                 clock = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 frame_valid = 1'b0;
  logic                 frame_ready;
  logic                 hist_start;
  logic                 hist_done = 1'b0;
  logic                 cdf_valid = 1'b0;
  logic [CDF_MIN_W-1:0] cdf_min_in = '0;
  logic [CDF_MIN_W-1:0] cdf_min;
  logic                 map_start;
  logic                 map_done = 1'b0;
  logic                 input_base_offset;
  logic                 frame_done;
  logic                 frame_err;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_ibo = 1'b0;
  int frame_no = 0;

  always #5 clock = ~clock;

  heq_frame_sequencer #(
    .FLUSH_CYCLES(4),
    .CNT_W       (20)
`ifdef HEQ_SEQ_WATCHDOG_EN
    ,
    .WDOG_CYCLES (100)
`endif
  ) dut (
    .clock            (clock),
    .rst_n            (rst_n),
    .frame_valid      (frame_valid),
    .frame_ready      (frame_ready),
    .hist_start       (hist_start),
    .hist_done        (hist_done),
    .cdf_valid        (cdf_valid),
    .cdf_min_in       (cdf_min_in),
    .cdf_min          (cdf_min),
    .map_start        (map_start),
    .map_done         (map_done),
    .input_base_offset(input_base_offset),
    .frame_done       (frame_done),
    .frame_err        (frame_err),
    .busy             (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Packed view {ready, busy, hist_start, map_start, frame_done, frame_err, ibo}.
  function automatic logic [6:0] outs();
    return {frame_ready, busy, hist_start, map_start, frame_done, frame_err, input_base_offset};
  endfunction

  // Runs one frame from IDLE. Cycle c is the interval after the c-th edge;
  // inputs set in cycle c are sampled at edge c+1. With FLUSH_CYCLES=4:
  // FLUSH fv+1..fv+4, HIST fv+5..hd, MAP hd+1..md, DONE md+1, IDLE md+2.
  task automatic run_frame(input int fv, input bit hold, input int hold_from,
                           input int cdf1, input logic [19:0] v1,
                           input int cdf2, input logic [19:0] v2,
                           input int hd, input int md,
                           input bit exp_err, input logic [19:0] exp_cdf);
    logic       ibo0;
    logic [6:0] exp_v;
    ibo0 = exp_ibo;
    frame_no++;
    for (int c = 0; c <= md + 2; c++) begin
      if (c > 0) begin
        tick();
        exp_v[6] = (c <= fv) || (c >= md + 2);
        exp_v[5] = !exp_v[6];
        exp_v[4] = (c >= fv + 5) && (c <= hd);
        exp_v[3] = (c == hd + 1);
        exp_v[2] = (c == md + 1);
        exp_v[1] = exp_err && (c == md + 1);
        exp_v[0] = (c <= md + 1) ? ibo0 : ~ibo0;
        check($sformatf("f%0d_c%0d_outs", frame_no, c), 32'(outs()), 32'(exp_v));
      end
      frame_valid = (c == fv) || (hold && c >= hold_from);
      cdf_valid   = (c == cdf1) || (c == cdf2);
      cdf_min_in  = (c == cdf1) ? v1 : ((c == cdf2) ? v2 : 20'h0);
      hist_done   = (c == hd);
      map_done    = (c == md);
    end
    check($sformatf("f%0d_cdf_min", frame_no), 32'(cdf_min), 32'(exp_cdf));
    exp_ibo = ~ibo0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int fd_seen;

    // Reset held for three edges; everything but frame_ready is 0.
    repeat (3) @(posedge clock);
    #1;
    check("rst_outs", 32'(outs()), 32'b1000000);
    check("rst_cdf_min", 32'(cdf_min), 32'h0);
    @(negedge clock);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", 32'(frame_ready), 32'h1);

    // Single frame timed as in the reference scenario.
    run_frame(10, 1'b0, 0, 50, 20'h00123, -1, 20'h0, 60, 90, 1'b0, 20'h00123);

    // Reset pulse in the middle of HIST drops everything at once.
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    repeat (7) tick();
    check("midrst_pre_hist", 32'(hist_start), 32'h1);
    check("midrst_pre_ibo", 32'(input_base_offset), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outs", 32'(outs()), 32'b1000000);
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    fd_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (frame_done || busy) fd_seen++;
    end
    check("midrst_no_frame_done", 32'(fd_seen), 32'h0);
    exp_ibo = 1'b0;

    // Three frames back to back with frame_valid held high.
    run_frame(0, 1'b1, 0, 8, 20'h00011, -1, 20'h0, 20, 25, 1'b0, 20'h00011);
    run_frame(0, 1'b1, 0, 9, 20'h00022, -1, 20'h0, 21, 24, 1'b0, 20'h00022);
    run_frame(0, 1'b0, 0, 7, 20'h00033, -1, 20'h0, 15, 18, 1'b0, 20'h00033);

    // frame_valid raised during MAP is held off until IDLE; second cdf_valid ignored.
    run_frame(10, 1'b1, 53, 30, 20'h00123, 40, 20'h00456, 50, 60, 1'b0, 20'h00123);
    // The held request starts this frame; cdf_valid coincides with hist_done
    // and map_done lands in the first MAP cycle.
    run_frame(0, 1'b0, 0, 12, 20'h00789, -1, 20'h0, 12, 13, 1'b0, 20'h00789);

    // hist_done with no cdf_valid ever: error, cdf_min kept.
    run_frame(3, 1'b0, 0, -1, 20'h0, -1, 20'h0, 20, 25, 1'b1, 20'h00789);

`ifdef HEQ_SEQ_WATCHDOG_EN
    // hist_done never arrives: abort exactly 100 cycles after HIST entry.
    begin
      logic [6:0] exp_v;
      logic       ibo0;
      ibo0 = exp_ibo;
      frame_valid = 1'b1;
      for (int c = 1; c <= 106; c++) begin
        tick();
        frame_valid = 1'b0;
        exp_v[6] = (c >= 106);
        exp_v[5] = !exp_v[6];
        exp_v[4] = (c >= 5) && (c <= 104);
        exp_v[3] = 1'b0;
        exp_v[2] = (c == 105);
        exp_v[1] = (c == 105);
        exp_v[0] = (c <= 105) ? ibo0 : ~ibo0;
        check($sformatf("wdog_c%0d_outs", c), 32'(outs()), 32'(exp_v));
      end
      exp_ibo = ~ibo0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_heq_frame_sequencer
